// File: rtl/dnn_accel_pkg.sv
// Shared types and constants for the dnn_dot_engine slice: FSM states, CSR map,
// status/ctrl bit positions and the accumulator saturation test.
package dnn_accel_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdBias,
        StWtBias,
        StRdW,
        StWtW,
        StRdA,
        StWtA,
        StMac,
        StWrOut,
        StDone
    } state_e;

    // CSR word indices
    localparam logic [2:0] CSR_CMD  = 3'd0;
    localparam logic [2:0] CSR_BIAS = 3'd1;
    localparam logic [2:0] CSR_WPTR = 3'd2;
    localparam logic [2:0] CSR_APTR = 3'd3;
    localparam logic [2:0] CSR_OPTR = 3'd4;
    localparam logic [2:0] CSR_LEN  = 3'd5;
    localparam logic [2:0] CSR_CTRL = 3'd6;
    localparam logic [2:0] CSR_CLR  = 3'd7;

    // Status register bits
    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_ABORTED = 2;
    localparam int unsigned STAT_SAT     = 3;

    // Ctrl register bits
    localparam int unsigned CTRL_RELU = 0;
    localparam int unsigned CTRL_IRQ  = 1;

    // Command (index 7) bits
    localparam int unsigned CMD_CLEAR = 0;
    localparam int unsigned CMD_ABORT = 1;

    // Widest accumulator the saturation test accepts
    localparam int unsigned MAX_ACC_W = 192;

    typedef enum logic [1:0] {ClipNone, ClipHigh, ClipLow} clip_e;

    // Classifies a signed accumulator against the signed data_w-bit range.
    function automatic clip_e saturate_clip(input logic signed [MAX_ACC_W-1:0] acc,
                                            input int unsigned data_w);
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        hi = $signed((MAX_ACC_W'(1) << (data_w - 1)) - MAX_ACC_W'(1));
        lo = -$signed(MAX_ACC_W'(1) << (data_w - 1));
        if (acc > hi) return ClipHigh;
        if (acc < lo) return ClipLow;
        return ClipNone;
    endfunction

endpackage

// File: rtl/dnn_fx_mac.sv
// Signed fixed-point multiply-accumulate: acc += (w * a) >>> FRAC_BITS, with
// synchronous clear and bias load. Kept separate so the multiplier maps to DSPs.
module dnn_fx_mac #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned ACC_W     = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] load_val,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] a,
    output logic [ACC_W-1:0]  acc
);

    logic signed [2*DATA_W-1:0] w_ext;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [2*DATA_W-1:0] prod_sh;

    assign w_ext   = (2*DATA_W)'($signed(w));
    assign a_ext   = (2*DATA_W)'($signed(a));
    assign prod    = w_ext * a_ext;
    assign prod_sh = prod >>> FRAC_BITS;

    // Accumulator register: clear beats load beats accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_W'($signed(load_val));
        end else if (en) begin
            acc <= acc + ACC_W'(prod_sh);
        end
    end

endmodule

// File: rtl/dnn_dot_engine.sv
// Dot-product engine: CSR slave programs pointers/length, the FSM fetches the
// bias and w/a pairs over an Avalon-MM master, accumulates, saturates, applies
// optional ReLU and writes one result word.
module dnn_dot_engine
    import dnn_accel_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned FRAC_BITS = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        slv_address,
    input  logic              slv_read,
    input  logic              slv_write,
    input  logic [DATA_W-1:0] slv_writedata,
    output logic [DATA_W-1:0] slv_readdata,
    output logic [ADDR_W-1:0] mst_address,
    output logic              mst_read,
    output logic              mst_write,
    output logic [DATA_W-1:0] mst_writedata,
    input  logic [DATA_W-1:0] mst_readdata,
    input  logic              mst_readdatavalid,
    input  logic              mst_waitrequest,
    output logic              irq
);

    localparam int unsigned ACC_W = 2*DATA_W + LEN_W;
    localparam int unsigned STEP  = DATA_W / 8;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] csr_bias_q, csr_w_q, csr_a_q, csr_out_q;
    logic [LEN_W-1:0]  csr_len_q;
    logic [1:0]        csr_ctrl_q;
    logic [ADDR_W-1:0] b_ptr_q, w_ptr_q, a_ptr_q, o_ptr_q;
    logic [LEN_W-1:0]  len_q, cnt_q;
    logic [DATA_W-1:0] w_q, a_q;
    logic              done_q, aborted_q, sat_q, abort_pend_q;
    logic [DATA_W-1:0] rdata_q;
    logic [3:0]        status;
    logic              busy, start, clear, abort_wr, abort_req;
    logic              mac_load, mac_en, finish, quit;
    logic [ACC_W-1:0]  acc;
    clip_e             clip;
    logic [DATA_W-1:0] result;

    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign start     = slv_write && (slv_address == CSR_CMD) && !busy;
    assign clear     = slv_write && (slv_address == CSR_CLR) && slv_writedata[CMD_CLEAR];
    assign abort_wr  = slv_write && (slv_address == CSR_CLR) && slv_writedata[CMD_ABORT] && busy;
    assign abort_req = abort_pend_q || abort_wr;
    assign irq       = done_q & csr_ctrl_q[CTRL_IRQ];
    assign clip      = saturate_clip(MAX_ACC_W'($signed(acc)), DATA_W);

    dnn_fx_mac #(
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .clr     (quit),
        .load    (mac_load),
        .en      (mac_en),
        .load_val(mst_readdata),
        .w       (w_q),
        .a       (a_q),
        .acc     (acc)
    );

    // Saturate the accumulator to DATA_W, then optional ReLU.
    always_comb begin
        result = acc[DATA_W-1:0];
        if (clip == ClipHigh) result = {1'b0, {(DATA_W-1){1'b1}}};
        else if (clip == ClipLow) result = {1'b1, {(DATA_W-1){1'b0}}};
        if (csr_ctrl_q[CTRL_RELU] && result[DATA_W-1]) result = '0;
    end

    // Next state and master bus outputs; an abort is honoured once the bus is idle.
    always_comb begin
        state_d       = state_q;
        mst_read      = 1'b0;
        mst_write     = 1'b0;
        mst_address   = '0;
        mst_writedata = '0;
        mac_load      = 1'b0;
        mac_en        = 1'b0;
        finish        = 1'b0;
        quit          = 1'b0;
        unique case (state_q)
            StIdle:   if (start) state_d = StRdBias;
            StDone:   state_d = start ? StRdBias : StIdle;
            StRdBias: begin
                mst_read    = 1'b1;
                mst_address = b_ptr_q;
                if (!mst_waitrequest) state_d = StWtBias;
            end
            StWtBias: if (mst_readdatavalid) begin
                mac_load = 1'b1;
                if (abort_req) quit = 1'b1;
                else state_d = (len_q == '0) ? StWrOut : StRdW;
            end
            StRdW: begin
                mst_read    = 1'b1;
                mst_address = w_ptr_q;
                if (!mst_waitrequest) state_d = StWtW;
            end
            StWtW: if (mst_readdatavalid) begin
                if (abort_req) quit = 1'b1;
                else state_d = StRdA;
            end
            StRdA: begin
                mst_read    = 1'b1;
                mst_address = a_ptr_q;
                if (!mst_waitrequest) state_d = StWtA;
            end
            StWtA: if (mst_readdatavalid) begin
                if (abort_req) quit = 1'b1;
                else state_d = StMac;
            end
            StMac: begin
                mac_en = 1'b1;
                if (abort_req) quit = 1'b1;
                else state_d = ((cnt_q + LEN_W'(1)) == len_q) ? StWrOut : StRdW;
            end
            StWrOut: begin
                mst_write     = 1'b1;
                mst_address   = o_ptr_q;
                mst_writedata = result;
                if (!mst_waitrequest) begin
                    finish  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
        if (quit) state_d = StIdle;
    end

    // FSM state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state_q <= StIdle;
        else                state_q <= state_d;
    end

    // CSR write port; configuration is frozen while a job runs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            csr_bias_q <= '0;
            csr_w_q    <= '0;
            csr_a_q    <= '0;
            csr_out_q  <= '0;
            csr_len_q  <= '0;
            csr_ctrl_q <= '0;
        end else if (slv_write && !busy) begin
            case (slv_address)
                CSR_BIAS: csr_bias_q <= ADDR_W'(slv_writedata);
                CSR_WPTR: csr_w_q    <= ADDR_W'(slv_writedata);
                CSR_APTR: csr_a_q    <= ADDR_W'(slv_writedata);
                CSR_OPTR: csr_out_q  <= ADDR_W'(slv_writedata);
                CSR_LEN:  csr_len_q  <= slv_writedata[LEN_W-1:0];
                CSR_CTRL: csr_ctrl_q <= {slv_writedata[CTRL_IRQ], slv_writedata[CTRL_RELU]};
                default: ;
            endcase
        end
    end

    // Job working registers: latched pointers, operands and element counter.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            b_ptr_q <= '0;
            w_ptr_q <= '0;
            a_ptr_q <= '0;
            o_ptr_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            a_q     <= '0;
        end else if (start) begin
            b_ptr_q <= csr_bias_q;
            w_ptr_q <= csr_w_q;
            a_ptr_q <= csr_a_q;
            o_ptr_q <= csr_out_q;
            len_q   <= csr_len_q;
            cnt_q   <= '0;
        end else if (mst_readdatavalid && (state_q == StWtW)) begin
            w_q     <= mst_readdata;
            w_ptr_q <= w_ptr_q + ADDR_W'(STEP);
        end else if (mst_readdatavalid && (state_q == StWtA)) begin
            a_q     <= mst_readdata;
            a_ptr_q <= a_ptr_q + ADDR_W'(STEP);
        end else if (mac_en) begin
            cnt_q   <= cnt_q + LEN_W'(1);
        end
    end

    // Sticky status flags and pending abort request.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            sat_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else if (start) begin
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            sat_q        <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            if (clear) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
                sat_q     <= 1'b0;
            end
            if (abort_wr) abort_pend_q <= 1'b1;
            if (finish) begin
                done_q       <= 1'b1;
                sat_q        <= (clip != ClipNone);
                abort_pend_q <= 1'b0;
            end
            if (quit) begin
                aborted_q    <= 1'b1;
                abort_pend_q <= 1'b0;
            end
        end
    end

    always_comb begin
        status               = '0;
        status[STAT_BUSY]    = busy;
        status[STAT_DONE]    = done_q;
        status[STAT_ABORTED] = aborted_q;
        status[STAT_SAT]     = sat_q;
    end

    // CSR read port with one cycle of latency.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rdata_q <= '0;
        end else if (slv_read) begin
            case (slv_address)
                CSR_CMD:  rdata_q <= DATA_W'(status);
                CSR_BIAS: rdata_q <= DATA_W'(csr_bias_q);
                CSR_WPTR: rdata_q <= DATA_W'(csr_w_q);
                CSR_APTR: rdata_q <= DATA_W'(csr_a_q);
                CSR_OPTR: rdata_q <= DATA_W'(csr_out_q);
                CSR_LEN:  rdata_q <= DATA_W'(csr_len_q);
                CSR_CTRL: rdata_q <= DATA_W'(csr_ctrl_q);
                default:  rdata_q <= '0;
            endcase
        end
    end

    assign slv_readdata = rdata_q;

endmodule

// File: doc/dnn_dot_engine.md
Name: dnn_dot_engine

Overview:
- Parametrised dot-product accelerator for the dnn_accel_system Qsys system.
- The CPU programs pointers and a length through an Avalon-MM CSR slave, then starts a job.
- The engine fetches the bias, then the weight/activation pairs from SDRAM over an Avalon-MM master, and multiply-accumulates in signed fixed point.
- It applies optional saturation and ReLU, writes one result word, and flags done/irq.
- New over the earlier accelerator: generic width and fraction, non-blocking status, saturation flag, abort, and interrupt.

Parameters:
- DATA_W, 32, word width of all data and CSR registers (multiple of 8).
- FRAC_BITS, 16, fractional bits of the signed fixed-point format (Q16.16 at defaults).
- ADDR_W, 32, master byte-address width.
- LEN_W, 16, width of the element-count register.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- slv_address  in  3  CSR word index
- slv_read  in  1  CSR read strobe
- slv_write  in  1  CSR write strobe
- slv_writedata  in  DATA_W  CSR write data
- slv_readdata  out  DATA_W  CSR read data, valid the cycle after slv_read
- mst_address  out  ADDR_W  byte address
- mst_read  out  1  read request
- mst_write  out  1  write request
- mst_writedata  out  DATA_W  result word
- mst_readdata  in  DATA_W  returned data
- mst_readdatavalid  in  1  read data valid
- mst_waitrequest  in  1  slave stall
- irq  out  1  level interrupt = done & irq_en

Behaviour:
- Reset: all outputs are 0, the FSM is IDLE, and all CSRs are 0. Reset is asynchronous and active-low, and acts mid-job with no output write issued.
- CSR map (word index):
  - 0 W: any write starts a job. 0 R: {.., sat, aborted, done, busy} in bits 3..0.
  - 1 bias ptr; 2 weight ptr; 3 activation ptr; 4 output ptr; 5 length (LEN_W LSBs).
  - 6 ctrl: bit0 relu_en, bit1 irq_en.
  - 7 W: bit0 clears done/aborted/sat; bit1 requests abort.
- While busy, writes to indices 0-6 are ignored. Reads are always allowed and have 1-cycle latency.
- FSM states: IDLE -> RD_BIAS -> WT_BIAS -> {RD_W -> WT_W -> RD_A -> WT_A -> MAC}×len -> WR_OUT -> DONE -> IDLE.
- Start handling: start clears done/aborted/sat, latches all pointers, loads acc with bias sign-extended and shifted left by 0, and sets busy.
- Master reads: in RD_* states mst_read=1 and the address is held until the cycle mst_waitrequest=0. Then the FSM goes to WT_*, which waits for mst_readdatavalid. Only one read is outstanding at a time.
- Pointer advance: the weight and activation pointers each advance by DATA_W/8 after their element is consumed.
- MAC: prod = signed w × signed a (2·DATA_W bits), arithmetically shifted right by FRAC_BITS. The accumulator is 2·DATA_W+LEN_W bits wide and never wraps. The element counter increments.
- Finishing sequence: after the MAC of the last element (or immediately after the bias when len=0):
  - result = saturate(acc) to DATA_W. Sat is set if clipped, to 0x7FFF_FFFF / 0x8000_0000 at defaults.
  - If relu_en and result<0, result=0.
  - WR_OUT holds mst_write, address and data until mst_waitrequest=0, then moves to DONE.
- DONE: busy=0, done=1 (sticky until a clear or a new start); 1 cycle later the FSM is in IDLE.
- Abort: a bit1 write while busy. The current bus transaction completes (read data or write acceptance). The FSM then goes to IDLE with aborted=1, done=0, and no output write.
  - An abort that lands during WR_OUT after the write was accepted is too late and still yields done.
- Clear and start in the same cycle are not possible (different indices); clear while busy affects only the sticky flags.
- Datapath latency: 1 MAC per 2 reads; no pipelining required.

Decomposition:
- Package dnn_accel_pkg holds:
  - the FSM state enum;
  - the CSR index constants;
  - the status bit positions;
  - the ctrl bit positions;
  - a saturate function.
- One sub-module, dnn_fx_mac: registered signed multiply, shift and accumulate with clear/load. This isolates the DSP inference.

Test Plan:
- Bias 0x0001_0000; w=[0x0002_0000×3]; a=[0x0000_8000×3]; len=3; relu off -> one write of 0x0004_0000 to the output ptr; status=0x2; irq=0.
- Bias 0xFFFF_0000 (−1.0); w=[0x0000_8000]; a=[0x0000_8000]; len=1 -> 0xFFFF_4000 with relu off, and 0x0000_0000 with relu_en=1.
- Bias 0x7FFF_0000; w=[0x0002_0000]; a=[0x0002_0000]; len=1 -> 0x7FFF_FFFF written; status sat=1 and done=1.
- len=0, bias 0x0003_0000, irq_en=1 -> exactly one read and one write of 0x0003_0000; irq rises when done; a write of 1 to index 7 drops irq.
- Random mst_waitrequest (50%) and readdatavalid delay of 0-5 cycles, len=8 -> address and read held stable while stalled; result identical to the zero-stall run; never more than one outstanding read.
- Abort written during the 3rd weight read; also reset_reset_n pulsed mid-job -> no output write; status aborted=1 (abort case) or all-zero (reset case); a new start then completes normally.
